// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the two-slave SPI DAC sequencer.
package spi_dac_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic OP_WRITE     = 1'b1;
  localparam logic OP_LOAD      = 1'b0;
  localparam int   WR_FRAME_LEN = 14;
  localparam int   LD_FRAME_LEN = 6;
  localparam int   REG_AW       = 3;
  localparam int   DATA_W       = 8;
  localparam int   CNT_W        = 4;

  // Frames are left-aligned in a WR_FRAME_LEN vector so both ops shift out from the MSB.
  function automatic logic [WR_FRAME_LEN-1:0] build_frame(
    input logic              wr,
    input logic              slv,
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    if (wr) begin
      return {OP_WRITE, slv, addr, data, 1'b0};
    end
    return {OP_LOAD, slv, addr, 1'b0, {DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// Two-way request arbiter producing a one-hot grant.
// Define SPI_SEQ_RR_EN for round-robin; otherwise req0 has fixed priority.
module spi_rr_arb
  import spi_dac_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
`ifdef SPI_SEQ_RR_EN
      if (valid == 2'b11) begin
        grant = last ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
`else
      if (valid[0]) begin
        grant = 2'b01;
      end else if (valid[1]) begin
        grant = 2'b10;
      end
`endif
    end
  end

`ifndef SPI_SEQ_RR_EN
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/spi_dac_seq.sv
// SPI master sequencer: arbitrates two requesters and serialises WRITE/LOAD frames.
// Arbitration policy selected by SPI_SEQ_RR_EN (defined = round-robin).
module spi_dac_seq
  import spi_dac_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_wr,
  input  logic [1:0]  req_slv,
  input  logic [5:0]  req_reg,
  input  logic [15:0] req_data,
  output logic        cs_n,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic        done_id
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  state_t                  state_reg, state_next;
  logic [WR_FRAME_LEN-1:0] shreg_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic [GAP_W-1:0]        gap_cnt_reg;
  logic                    last_reg;
  logic                    cur_id_reg;

  logic [1:0]              grant;
  logic                    g_idx;
  logic                    sel_wr;
  logic                    sel_slv;
  logic [REG_AW-1:0]       sel_reg;
  logic [DATA_W-1:0]       sel_data;
  logic [WR_FRAME_LEN-1:0] sel_frame;

  spi_rr_arb u_arb (
    .valid (req_valid),
    .en    (state_reg == IDLE),
    .last  (last_reg),
    .grant (grant)
  );

  assign req_ready = grant;
  assign busy      = (state_reg != IDLE);
  assign g_idx     = grant[1];
  assign sel_wr    = g_idx ? req_wr[1]       : req_wr[0];
  assign sel_slv   = g_idx ? req_slv[1]      : req_slv[0];
  assign sel_reg   = g_idx ? req_reg[5:3]    : req_reg[2:0];
  assign sel_data  = g_idx ? req_data[15:8]  : req_data[7:0];
  assign sel_frame = build_frame(sel_wr, sel_slv, sel_reg, sel_data);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|grant) state_next = SHIFT;
      SHIFT:   if (bit_cnt_reg == '0) state_next = GAP;
      GAP:     if (gap_cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cs_n        <= 1'b1;
      mosi        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      last_reg    <= 1'b1;
      cur_id_reg  <= 1'b0;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            cs_n        <= 1'b0;
            mosi        <= sel_frame[WR_FRAME_LEN-1];
            shreg_reg   <= {sel_frame[WR_FRAME_LEN-2:0], 1'b0};
            bit_cnt_reg <= sel_wr ? CNT_W'(WR_FRAME_LEN - 1) : CNT_W'(LD_FRAME_LEN - 1);
            last_reg    <= g_idx;
            cur_id_reg  <= g_idx;
          end
        end
        SHIFT: begin
          if (bit_cnt_reg == '0) begin
            cs_n        <= 1'b1;
            mosi        <= 1'b0;
            done        <= 1'b1;
            done_id     <= cur_id_reg;
            gap_cnt_reg <= GAP_W'(IDLE_GAP - 1);
          end else begin
            mosi        <= shreg_reg[WR_FRAME_LEN-1];
            shreg_reg   <= {shreg_reg[WR_FRAME_LEN-2:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_reg != '0) gap_cnt_reg <= gap_cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
